// File: rtl/seg7_frame_capture_if.sv
// Seven-segment receive bus plus decoded-frame outputs of seg7_frame_capture.
// master = side driving the LED bus and consuming frames; slave = the capture block.
interface seg7_frame_capture_if;
    logic       an3, an2, an1, an0;
    logic       a, b, c, d, e, f, g;
    logic       dp;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [3:0] dp_flags;
    logic [3:0] invalid_flags;
    logic       frame_valid;
    logic       frame_err;

    modport master (
        output an3, an2, an1, an0, a, b, c, d, e, f, g, dp,
        input  digit3, digit2, digit1, digit0, dp_flags, invalid_flags,
               frame_valid, frame_err
    );

    modport slave (
        input  an3, an2, an1, an0, a, b, c, d, e, f, g, dp,
        output digit3, digit2, digit1, digit0, dp_flags, invalid_flags,
               frame_valid, frame_err
    );
endinterface

// File: rtl/seg7_frame_capture.sv
// Samples a multiplexed active-low 4-digit seven-segment bus, decodes each settled digit
// and emits complete frames. Define SEG7_CAP_ORDER_CHECK_EN to enforce an3->an2->an1->an0 order.
module seg7_frame_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_frame_capture_if.slave  bus
);
    // state  | meaning
    // IDLE   | no single anode low, nothing to capture
    // SETTLE | one anode low, counting identical samples
    // HELD   | digit captured, waiting for the bus to change
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [11:0]      in_q, in_p;       // {an3..an0, a..g, dp}
    logic [SW-1:0]    stable_cnt, stable_nxt;
    logic [TW-1:0]    tmo_cnt;
    logic [3:0]       mask, sdp, sinv;
    logic [3:0][3:0]  shadow;
    logic             anode_valid;
    logic [1:0]       sel;
    logic [3:0]       sel_bit;
    logic [3:0]       code;
    logic             code_inv;
    logic             capture;

    always_comb begin
        anode_valid = 1'b1;
        sel         = 2'd0;
        case (in_q[11:8])
            4'b0111: sel = 2'd3;
            4'b1011: sel = 2'd2;
            4'b1101: sel = 2'd1;
            4'b1110: sel = 2'd0;
            default: anode_valid = 1'b0;
        endcase
    end

    always_comb begin
        code     = 4'h0;
        code_inv = 1'b0;
        case (in_q[7:1])
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b0001000: code = 4'hA;
            7'b1100000: code = 4'hB;
            7'b0110001: code = 4'hC;
            7'b1000010: code = 4'hD;
            7'b0110000: code = 4'hE;
            7'b0111000: code = 4'hF;
            default:    code_inv = 1'b1;
        endcase
    end

    // Next count includes the current comparison so a capture never takes a just-changed sample.
    always_comb begin
        stable_nxt = '0;
        if (in_q == in_p)
            stable_nxt = (stable_cnt == SETTLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end

    assign sel_bit = 4'b0001 << sel;
    assign capture = (state == SETTLE) && anode_valid && (stable_nxt >= SETTLE_HIT);

`ifdef SEG7_CAP_ORDER_CHECK_EN
    logic [1:0] last_idx;
    logic       in_order;
    // An empty mask accepts any digit; otherwise repeat the last digit or take the next in scan order.
    assign in_order = (mask == 4'h0) || (sel == last_idx) || (sel == last_idx - 2'd1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            in_q              <= '0;
            in_p              <= '0;
            stable_cnt        <= '0;
            tmo_cnt           <= '0;
            mask              <= '0;
            sdp               <= '0;
            sinv              <= '0;
            shadow            <= '0;
            bus.digit3        <= '0;
            bus.digit2        <= '0;
            bus.digit1        <= '0;
            bus.digit0        <= '0;
            bus.dp_flags      <= '0;
            bus.invalid_flags <= '0;
            bus.frame_valid   <= 1'b0;
            bus.frame_err     <= 1'b0;
`ifdef SEG7_CAP_ORDER_CHECK_EN
            last_idx          <= '0;
`endif
        end else begin
            in_q <= {bus.an3, bus.an2, bus.an1, bus.an0,
                     bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.dp};
            in_p <= in_q;
            stable_cnt      <= stable_nxt;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;

            case (state)
                IDLE:    if (anode_valid) state <= SETTLE;
                SETTLE:  if (!anode_valid) state <= IDLE;
                         else if (capture) state <= HELD;
                HELD:    if (in_q != in_p) state <= anode_valid ? SETTLE : IDLE;
                default: state <= IDLE;
            endcase

            if (mask == 4'hF) begin
                bus.digit3        <= shadow[3];
                bus.digit2        <= shadow[2];
                bus.digit1        <= shadow[1];
                bus.digit0        <= shadow[0];
                bus.dp_flags      <= sdp;
                bus.invalid_flags <= sinv;
                bus.frame_valid   <= 1'b1;
                mask              <= '0;
                tmo_cnt           <= '0;
            end else if (capture) begin
                shadow[sel] <= code;
                sdp[sel]    <= ~in_q[0];
                sinv[sel]   <= code_inv;
                tmo_cnt     <= TMO_LOAD;
`ifdef SEG7_CAP_ORDER_CHECK_EN
                last_idx <= sel;
                if (!in_order) begin
                    bus.frame_err <= 1'b1;
                    mask          <= sel_bit;
                end else begin
                    mask <= mask | sel_bit;
                end
`else
                mask <= mask | sel_bit;
`endif
            end else if (mask != 4'h0) begin
                // Remaining-cycles timer; terminal count abandons the partial frame.
                if (tmo_cnt == '0) begin
                    bus.frame_err <= 1'b1;
                    mask          <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_frame_capture.sv
// Bench for seg7_frame_capture: directed scenarios plus random scans checked against a
// run-length/queue reference model of the capture and frame rules.
module tb_seg7_frame_capture;
    localparam int S = 4;
    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] bus = '1;            // {an3..an0, a..g, dp}
    logic [23:0] obs;

    seg7_frame_capture_if bif();
    assign {bif.an3, bif.an2, bif.an1, bif.an0,
            bif.a, bif.b, bif.c, bif.d, bif.e, bif.f, bif.g, bif.dp} = bus;
    assign obs = {bif.digit3, bif.digit2, bif.digit1, bif.digit0, bif.dp_flags, bif.invalid_flags};

    seg7_frame_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [3:0] ghosts [4] = '{4'b0000, 4'b0011, 4'b1111, 4'b0101};

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int d_fv_cnt = 0, d_fe_cnt = 0, d_fv_cyc = -1, d_fe_cyc = -1;
    int e_fv_cnt = 0, e_fe_cnt = 0, e_fv_cyc = -1, e_fe_cyc = -1;

    logic [11:0] m_prev;
    int          m_run;
    logic        pend_cap, pend_done;
    logic [11:0] pend_word;
    logic [3:0]  m_mask, m_sdp, m_sinv;
    logic [3:0]  m_sh [4];
    int          m_cap_cyc, m_last;
    logic [3:0]  e_dig [4];
    logic [3:0]  e_dpf, e_inv;

    function automatic int anode_idx(input logic [3:0] an);
        int lows = 0;
        int pos = -1;
        for (int k = 0; k < 4; k++)
            if (!an[k]) begin lows++; pos = k; end
        return (lows == 1) ? pos : -1;
    endfunction

    function automatic logic [4:0] decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (pat[k] == s) return {1'b0, 4'(k)};
        return 5'b10000;
    endfunction

    function automatic logic [23:0] expv();
        return {e_dig[3], e_dig[2], e_dig[1], e_dig[0], e_dpf, e_inv};
    endfunction

    task automatic model_reset();
        m_prev = '0; m_run = 0; pend_cap = 0; pend_done = 0; pend_word = '0;
        m_mask = '0; m_sdp = '0; m_sinv = '0; m_cap_cyc = 0; m_last = 0;
        e_dpf = '0; e_inv = '0;
        for (int k = 0; k < 4; k++) begin m_sh[k] = '0; e_dig[k] = '0; end
    endtask

    // One clock edge of the reference: a word held for S consecutive samples with exactly one
    // anode low is captured on the following edge; a full mask publishes one edge later.
    task automatic model_step(input logic [11:0] w);
        int i;
        logic [4:0] dc;
        if (pend_done) begin
            e_fv_cnt++; e_fv_cyc = cyc;
            for (int k = 0; k < 4; k++) e_dig[k] = m_sh[k];
            e_dpf = m_sdp; e_inv = m_sinv; m_mask = '0; pend_done = 0;
        end else if (pend_cap) begin
            i = anode_idx(pend_word[11:8]);
            dc = decode(pend_word[7:1]);
            m_sh[i] = dc[3:0]; m_sinv[i] = dc[4]; m_sdp[i] = ~pend_word[0];
            m_cap_cyc = cyc;
`ifdef SEG7_CAP_ORDER_CHECK_EN
            if (m_mask != 0 && i != m_last && i != (m_last + 3) % 4) begin
                e_fe_cnt++; e_fe_cyc = cyc; m_mask = 4'(1 << i);
            end else begin
                m_mask[i] = 1'b1;
            end
            m_last = i;
`else
            m_mask[i] = 1'b1;
`endif
            if (m_mask == 4'hF) pend_done = 1;
        end else if (m_mask != 0 && cyc - m_cap_cyc == T) begin
            e_fe_cnt++; e_fe_cyc = cyc; m_mask = '0;
        end
        pend_cap = 0;
        if (w == m_prev) m_run++;
        else begin m_run = 1; m_prev = w; end
        if (m_run == S && anode_idx(w[11:8]) >= 0) begin pend_cap = 1; pend_word = w; end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_step(bus);
        #1;
        if (bif.frame_valid) begin d_fv_cnt++; d_fv_cyc = cyc; end
        if (bif.frame_err) begin d_fe_cnt++; d_fe_cyc = cyc; end
    endtask

    task automatic show(input int dig, input logic [6:0] s, input logic dpn, input int n);
        logic [3:0] an;
        an = 4'b0001 << dig;
        bus = {~an, s, dpn};
        repeat (n) tick();
    endtask

    task automatic blank(input int n);
        bus = '1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus = '1;
        repeat (3) tick();
        cmp_cnt++;
        if (obs !== 24'h0 || {bif.frame_valid, bif.frame_err} !== 2'b00) begin
            err_cnt++; $display("FAIL reset_outputs: got %h/%b%b want 0", obs, bif.frame_valid, bif.frame_err);
        end
        reset = 1'b0;
        blank(2000);
        cmp_cnt++;
        if (obs !== 24'h0 || d_fv_cnt !== 0 || d_fe_cnt !== 0) begin
            err_cnt++; $display("FAIL idle_bus: outputs %h fv %0d fe %0d want 0 0 0", obs, d_fv_cnt, d_fe_cnt);
        end
    endtask

    task automatic test_basic_frame();
        int fv0, c0;
        fv0 = d_fv_cnt;
        show(3, pat[1], 1'b1, 8);
        show(2, pat[2], 1'b1, 8);
        show(1, pat[3], 1'b1, 8);
        c0 = cyc;
        show(0, pat[4], 1'b1, 8);
        blank(4);
        cmp_cnt++;
        if (d_fv_cnt !== fv0 + 1 || d_fv_cyc !== c0 + S + 2) begin
            err_cnt++; $display("FAIL basic_valid: count %0d cycle %0d want %0d %0d", d_fv_cnt, d_fv_cyc, fv0 + 1, c0 + S + 2);
        end
        cmp_cnt++;
        if (obs !== 24'h1234_00 || obs !== expv()) begin
            err_cnt++; $display("FAIL basic_frame: got %h want %h model %h", obs, 24'h1234_00, expv());
        end
    endtask

    task automatic test_bounce();
        int fv0, ca;
        fv0 = d_fv_cnt;
        show(1, pat[6], 1'b1, 8);
        show(0, pat[14], 1'b1, 8);
        show(3, pat[11], 1'b1, 8);
        for (int k = 0; k < 5; k++) show(2, (k % 2 == 0) ? 7'b1001000 : pat[10], 1'b1, 2);
        ca = cyc;
        show(2, pat[10], 1'b0, 8);
        blank(4);
        cmp_cnt++;
        if (d_fv_cnt !== fv0 + 1 || d_fv_cyc !== ca + S + 2) begin
            err_cnt++; $display("FAIL bounce_valid: count %0d cycle %0d want %0d %0d", d_fv_cnt, d_fv_cyc, fv0 + 1, ca + S + 2);
        end
        cmp_cnt++;
        if (obs !== 24'hBA6E_40 || obs !== expv()) begin
            err_cnt++; $display("FAIL bounce_frame: got %h want %h", obs, 24'hBA6E_40);
        end
    endtask

    task automatic test_invalid();
        show(3, pat[7], 1'b1, 8);
        show(2, pat[8], 1'b1, 8);
        show(1, 7'b0110110, 1'b1, 8);
        show(0, 7'b1111111, 1'b1, 8);
        blank(4);
        cmp_cnt++;
        if (obs !== 24'h7800_03 || obs !== expv() || d_fv_cnt !== e_fv_cnt) begin
            err_cnt++; $display("FAIL invalid_frame: got %h want %h (fv %0d/%0d)", obs, 24'h7800_03, d_fv_cnt, e_fv_cnt);
        end
    endtask

    task automatic test_timeout();
        int fv0, fe0, c2;
        fv0 = d_fv_cnt; fe0 = d_fe_cnt;
        show(3, pat[9], 1'b1, 8);
        c2 = cyc;
        show(2, pat[12], 1'b1, 8);
        blank(T + 20);
        cmp_cnt++;
        if (d_fe_cnt !== fe0 + 1 || d_fe_cyc !== c2 + 1 + S + T || d_fv_cnt !== fv0) begin
            err_cnt++; $display("FAIL timeout_err: count %0d cycle %0d fv %0d want %0d %0d %0d",
                                d_fe_cnt, d_fe_cyc, d_fv_cnt, fe0 + 1, c2 + 1 + S + T, fv0);
        end
        show(3, pat[13], 1'b1, 8);
        show(2, pat[15], 1'b1, 8);
        show(1, pat[0], 1'b1, 8);
        show(0, pat[9], 1'b0, 8);
        blank(4);
        cmp_cnt++;
        if (obs !== 24'hDF09_10 || d_fv_cnt !== fv0 + 1 || d_fe_cnt !== fe0 + 1) begin
            err_cnt++; $display("FAIL timeout_recover: got %h fv %0d fe %0d want %h %0d %0d",
                                obs, d_fv_cnt, d_fe_cnt, 24'hDF09_10, fv0 + 1, fe0 + 1);
        end
    endtask

    task automatic test_ghost();
        int fv0, fe0;
        fv0 = d_fv_cnt; fe0 = d_fe_cnt;
        bus = {4'b0011, pat[8], 1'b1};
        repeat (20) tick();
        blank(T + 10);
        cmp_cnt++;
        if (d_fv_cnt !== fv0 || d_fe_cnt !== fe0 || e_fe_cnt !== d_fe_cnt) begin
            err_cnt++; $display("FAIL ghost_anodes: fv %0d fe %0d want %0d %0d", d_fv_cnt, d_fe_cnt, fv0, fe0);
        end
    endtask

    task automatic test_reset_midframe();
        int fv0, fe0;
        fv0 = d_fv_cnt; fe0 = d_fe_cnt;
        show(3, pat[3], 1'b1, 8);
        show(2, pat[5], 1'b1, 8);
        bus = '1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        blank(T + 20);
        cmp_cnt++;
        if (obs !== 24'h0 || d_fv_cnt !== fv0 || d_fe_cnt !== fe0) begin
            err_cnt++; $display("FAIL reset_midframe: got %h fv %0d fe %0d want 0 %0d %0d", obs, d_fv_cnt, d_fe_cnt, fv0, fe0);
        end
    endtask

    task automatic test_random();
        int order [4];
        int j, tmp;
        logic [6:0] s;
        for (int fr = 0; fr < 10; fr++) begin
            order = '{3, 2, 1, 0};
            if ($urandom_range(0, 3) == 0)
                for (int k = 3; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    tmp = order[k]; order[k] = order[j]; order[j] = tmp;
                end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    bus = {ghosts[$urandom_range(0, 3)], pat[8], 1'b1};
                    repeat ($urandom_range(1, 3)) tick();
                end
                if ($urandom_range(0, 7) == 0) s = 7'($urandom);
                else s = pat[$urandom_range(0, 15)];
                show(order[k], s, 1'($urandom_range(0, 1)), $urandom_range(S - 1, 9));
            end
            blank($urandom_range(0, 6));
            cmp_cnt++;
            if (d_fv_cnt !== e_fv_cnt || d_fv_cyc !== e_fv_cyc || d_fe_cnt !== e_fe_cnt || obs !== expv()) begin
                err_cnt++; $display("FAIL random_frame%0d: fv %0d@%0d fe %0d out %h want fv %0d@%0d fe %0d out %h",
                                    fr, d_fv_cnt, d_fv_cyc, d_fe_cnt, obs, e_fv_cnt, e_fv_cyc, e_fe_cnt, expv());
            end
        end
        blank(T + 20);
        cmp_cnt++;
        if (d_fe_cnt !== e_fe_cnt || d_fe_cyc !== e_fe_cyc || d_fv_cnt !== e_fv_cnt) begin
            err_cnt++; $display("FAIL random_flush: fe %0d@%0d fv %0d want %0d@%0d %0d",
                                d_fe_cnt, d_fe_cyc, d_fv_cnt, e_fe_cnt, e_fe_cyc, e_fv_cnt);
        end
    endtask

`ifdef SEG7_CAP_ORDER_CHECK_EN
    task automatic test_order();
        int fe0, c1;
        fe0 = d_fe_cnt;
        show(3, pat[1], 1'b1, 8);
        c1 = cyc;
        show(1, pat[2], 1'b1, 8);
        cmp_cnt++;
        if (d_fe_cnt !== fe0 + 1 || d_fe_cyc !== c1 + 1 + S) begin
            err_cnt++; $display("FAIL order_err: count %0d cycle %0d want %0d %0d", d_fe_cnt, d_fe_cyc, fe0 + 1, c1 + 1 + S);
        end
        blank(T + 20);
        cmp_cnt++;
        if (d_fe_cnt !== e_fe_cnt || d_fe_cnt !== fe0 + 2) begin
            err_cnt++; $display("FAIL order_timeout: count %0d want %0d", d_fe_cnt, fe0 + 2);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_bounce();
        test_invalid();
        test_timeout();
        test_ghost();
        test_reset_midframe();
        test_random();
`ifdef SEG7_CAP_ORDER_CHECK_EN
        test_order();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
